// File: rtl/core_run_ctrl_pkg.sv
// core_run_ctrl_pkg: shared sizes and run-control state encodings
package core_run_ctrl_pkg;
  localparam int DEF_IMEM_DEPTH = 64;
  localparam int DEF_ADDR_W = $clog2(DEF_IMEM_DEPTH);
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_HALT    = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_STEP    = 3'd5;
endpackage

// File: rtl/core_run_ctrl_imem_loader.sv
// core_run_ctrl_imem_loader: I-mem write pointer, overflow/last detection and write strobes
module core_run_ctrl_imem_loader
  import core_run_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_IMEM_DEPTH,
  parameter int AW = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready_i,
  input  logic          clr_i,
  input  logic          load_valid_i,
  input  logic [31:0]   load_data_i,
  input  logic          load_last_i,
  output logic          accept_o,
  output logic          last_o,
  output logic          ovf_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_waddr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          load_err_o
);
  logic [AW-1:0] wptr_q, wptr_d;
  logic          err_q, err_d;
  assign accept_o = load_valid_i & ready_i;
  assign last_o = accept_o & load_last_i;
  // the last slot is still written; the image is declared bad only after it
  assign ovf_o = accept_o & ~load_last_i & (wptr_q == AW'(DEPTH - 1));
  assign imem_we_o = accept_o;
  assign imem_waddr_o = wptr_q;
  assign imem_wdata_o = load_data_i;
  assign load_err_o = err_q;
  always_comb begin
    wptr_d = (clr_i || ovf_o) ? '0 : accept_o ? wptr_q + AW'(1) : wptr_q;
    err_d = ovf_o ? 1'b1 : accept_o ? 1'b0 : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: program load, core reset hold and run/halt/step/breakpoint PC gating
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic              cmd_reload,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc_cur,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              pc_en,
  output logic              halted,
  output logic              load_err,
  output logic [31:0]       cycle_cnt
);
  logic [2:0]  state_q, state_d;
  logic        resume_q, resume_d;
  logic [31:0] cnt_q, cnt_d;
  logic        accept, last, ovf, bp_hit;
  core_run_ctrl_imem_loader #(.DEPTH(IMEM_DEPTH), .AW(ADDR_W)) u_loader (
    .clk(clk),
    .reset(reset),
    .ready_i(load_ready),
    .clr_i(state_q == ST_RELEASE),
    .load_valid_i(load_valid),
    .load_data_i(load_data),
    .load_last_i(load_last),
    .accept_o(accept),
    .last_o(last),
    .ovf_o(ovf),
    .imem_we_o(imem_we),
    .imem_waddr_o(imem_waddr),
    .imem_wdata_o(imem_wdata),
    .load_err_o(load_err)
  );
  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign core_rst = load_ready || (state_q == ST_RELEASE);
  assign halted = state_q == ST_HALT;
  // resume masks the breakpoint so a run issued while parked on it can leave
  assign bp_hit = bp_en & (pc_cur == bp_addr) & ~resume_q;
  assign pc_en = (state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_hit);
  assign cycle_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LOAD: state_d = last ? ST_RELEASE : ovf ? ST_IDLE : accept ? ST_LOAD : state_q;
      ST_RELEASE:       state_d = ST_HALT;
      ST_HALT:          state_d = cmd_reload ? ST_IDLE : cmd_step ? ST_STEP : cmd_run ? ST_RUN : ST_HALT;
      ST_RUN:           state_d = (bp_hit || cmd_halt) ? ST_HALT : ST_RUN;
      ST_STEP:          state_d = ST_HALT;
      default:          state_d = ST_IDLE;
    endcase
    resume_d = (state_q == ST_HALT) && (state_d == ST_RUN);
    cnt_d = (state_q == ST_RELEASE) ? 32'd0 : cnt_q + {31'd0, pc_en};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      resume_q <= 1'b0;
      cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      resume_q <= resume_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed stimulus, per-cycle model comparison plus literal spot checks
module tb_core_run_ctrl;
  logic        clk = 0, reset = 1, load_valid = 0, load_last = 0;
  logic        cmd_run = 0, cmd_halt = 0, cmd_step = 0, cmd_reload = 0, bp_en = 0;
  logic [31:0] load_data = 0, bp_addr = 0, pc_cur = 0;
  logic        load_ready, imem_we, core_rst, pc_en, halted, load_err;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata, cycle_cnt;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  core_run_ctrl dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
    .cmd_step(cmd_step), .cmd_reload(cmd_reload), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc_cur(pc_cur), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .pc_en(pc_en), .halted(halted), .load_err(load_err),
    .cycle_cnt(cycle_cnt)
  );

  // stand-in for the core: PC cleared while held in reset, +4 per enabled cycle
  always @(posedge clk) pc_cur <= core_rst ? 32'd0 : pc_cur + (pc_en ? 32'd4 : 32'd0);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  typedef enum {M_IDLE, M_LOAD, M_REL, M_HALT, M_RUN, M_STEP} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_wptr = 0;
  bit          m_err = 0, m_resume = 0, started = 0;
  logic [31:0] m_cnt = 0;

  function automatic bit m_ready();
    return m_mode == M_IDLE || m_mode == M_LOAD;
  endfunction

  function automatic bit m_pc_en();
    return m_mode == M_STEP || (m_mode == M_RUN && !(bp_en && pc_cur == bp_addr && !m_resume));
  endfunction

  always @(posedge clk) begin
    bit acc, pe;
    acc = load_valid && m_ready();
    pe = m_pc_en();
    started = 1;
    if (reset) begin
      m_mode = M_IDLE; m_wptr = 0; m_err = 0; m_cnt = 0; m_resume = 0;
    end else begin
      m_cnt = m_cnt + (pe ? 32'd1 : 32'd0);
      if (acc) begin
        if (load_last) begin m_mode = M_REL; m_wptr++; m_err = 0; end
        else if (m_wptr == 63) begin m_mode = M_IDLE; m_wptr = 0; m_err = 1; end
        else begin m_mode = M_LOAD; m_wptr++; m_err = 0; end
      end else begin
        case (m_mode)
          M_REL: begin m_cnt = 0; m_wptr = 0; m_mode = M_HALT; end
          M_HALT:
            if (cmd_reload) m_mode = M_IDLE;
            else if (cmd_step) m_mode = M_STEP;
            else if (cmd_run) begin m_mode = M_RUN; m_resume = 1; end
          M_RUN: begin m_resume = 0; if (!pe || cmd_halt) m_mode = M_HALT; end
          M_STEP: m_mode = M_HALT;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) if (started) begin
    bit acc;
    acc = load_valid && m_ready();
    chk("load_ready", load_ready, m_ready());
    chk("imem_we", imem_we, acc);
    if (acc) begin
      chk("imem_waddr", imem_waddr, m_wptr[5:0]);
      chk("imem_wdata", imem_wdata, load_data);
    end
    chk("core_rst", core_rst, m_mode inside {M_IDLE, M_LOAD, M_REL});
    chk("halted", halted, m_mode == M_HALT);
    chk("pc_en", pc_en, m_pc_en());
    chk("load_err", load_err, m_err);
    chk("cycle_cnt", cycle_cnt, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick(); tick(); reset = 0;
    @(negedge clk);
    chk("rst_core_rst", core_rst, 1); chk("rst_pc_en", pc_en, 0);
    chk("rst_cnt", cycle_cnt, 0); chk("rst_ready", load_ready, 1);
    tick(); cmd_run = 1; cmd_step = 1;
    tick(); cmd_run = 0; cmd_step = 0;
    @(negedge clk);
    chk("idle_ignore_ready", load_ready, 1); chk("idle_ignore_halted", halted, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); load_valid = 1; load_data = 32'hA000_0000 + i; load_last = (i == 2);
      @(negedge clk);
      chk("ld3_we", imem_we, 1); chk("ld3_waddr", imem_waddr, i);
    end
    tick(); load_valid = 0; load_last = 0;
    @(negedge clk);
    chk("release_rst", core_rst, 1); chk("release_halted", halted, 0);
    tick();
    @(negedge clk);
    chk("halt_halted", halted, 1); chk("halt_core_rst", core_rst, 0);
    tick(); cmd_step = 1;
    tick(); cmd_step = 0;
    @(negedge clk); chk("step1_pc_en", pc_en, 1);
    tick();
    @(negedge clk); chk("step1_gap", pc_en, 0);
    tick(); cmd_step = 1;
    tick(); cmd_step = 0;
    tick();
    @(negedge clk); chk("step2_cnt", cycle_cnt, 2); chk("step2_pc_en", pc_en, 0);
    tick(); cmd_reload = 1; cmd_run = 1;
    tick(); cmd_reload = 0; cmd_run = 0;
    @(negedge clk);
    chk("reload_ready", load_ready, 1); chk("reload_core_rst", core_rst, 1); chk("reload_halted", halted, 0);
    tick(); load_valid = 1; load_data = 32'h13; load_last = 1;
    tick(); load_valid = 0; load_last = 0;
    tick();
    @(negedge clk); chk("bp_cnt0", cycle_cnt, 0); chk("bp_halted0", halted, 1);
    tick(); bp_en = 1; bp_addr = 32'h8; cmd_run = 1;
    tick(); cmd_run = 0;
    tick(); tick();
    @(negedge clk); chk("bp_pc_en", pc_en, 0);
    tick();
    @(negedge clk); chk("bp_halted", halted, 1); chk("bp_cnt", cycle_cnt, 2);
    tick(); cmd_run = 1;
    tick(); cmd_run = 0;
    @(negedge clk); chk("resume_pc_en", pc_en, 1);
    tick();
    @(negedge clk); chk("resume_past_bp", cycle_cnt, 3); chk("resume_pc_en2", pc_en, 1);
    tick(); cmd_halt = 1; bp_en = 0;
    tick(); cmd_halt = 0;
    @(negedge clk); chk("halt_cnt", cycle_cnt, 5); chk("halt_halted2", halted, 1);
    tick(); cmd_run = 1;
    tick(); cmd_run = 0;
    repeat (5) tick();
    cmd_halt = 1;
    tick(); cmd_halt = 0;
    @(negedge clk); chk("run6_cnt", cycle_cnt, 11); chk("run6_halted", halted, 1);
    tick(); cmd_reload = 1;
    tick(); cmd_reload = 0;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1; load_data = i * 3 + 1; load_last = 0;
      if (i == 63) begin
        @(negedge clk); chk("ovf_last_waddr", imem_waddr, 63); chk("ovf_last_we", imem_we, 1);
      end
      tick();
    end
    load_valid = 0;
    @(negedge clk);
    chk("ovf_err", load_err, 1); chk("ovf_ready", load_ready, 1); chk("ovf_core_rst", core_rst, 1);
    tick(); load_valid = 1; load_last = 1; load_data = 32'hDEAD;
    @(negedge clk); chk("ovf_wrap_waddr", imem_waddr, 0); chk("ovf_err_held", load_err, 1);
    tick(); load_valid = 0; load_last = 0;
    @(negedge clk); chk("ovf_err_clr", load_err, 0); chk("ovf_release_ready", load_ready, 0);
    tick(); tick(); cmd_reload = 1;
    tick(); cmd_reload = 0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1; load_data = 32'h100 + i;
      tick();
    end
    reset = 1; load_valid = 0;
    tick(); reset = 0;
    @(negedge clk);
    chk("midrst_core_rst", core_rst, 1); chk("midrst_ready", load_ready, 1); chk("midrst_cnt", cycle_cnt, 0);
    tick(); load_valid = 1; load_data = 32'h5;
    @(negedge clk); chk("midrst_waddr", imem_waddr, 0);
    tick(); load_valid = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
